// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel stream sequencer.
// Frame geometry defaults, FSM/mode enums and the filter-select helper.
package sobel_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;
    localparam int DW_DEF    = 12;
    localparam int COORD_W   = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } ctrl_st_t;

    typedef enum logic [1:0] {
        MODE_V   = 2'd0,
        MODE_H   = 2'd1,
        MODE_ALT = 2'd2
    } sobel_mode_t;

    // Both 2'b10 and 2'b11 select the per-frame alternating filter.
    function automatic logic filterFor(input logic [1:0] mode, input logic toggle);
        logic sel;
        case (mode)
            MODE_V:  sel = 1'b0;
            MODE_H:  sel = 1'b1;
            default: sel = toggle;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sobel_xy_counter.sv
// Raster X/Y position counter; X wraps at the line end, Y only runs forward so
// flush pixels land on rows past the frame. A clear returns it to (0,0).
module sobel_xy_counter
    import sobel_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iEn,
    input  logic       iClr,
    output logic [9:0] oX,
    output logic [9:0] oY,
    output logic       oXLast,
    output logic       oYLast
);

    localparam coord_t X_LAST = coord_t'(H_ACT - 1);
    localparam coord_t Y_LAST = coord_t'(V_ACT - 1);

    coord_t xCnt_r;
    coord_t yCnt_r;

    // Advance position on enable; clear has priority so a frame restarts at (0,0).
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            xCnt_r <= '0;
            yCnt_r <= '0;
        end else if (iClr) begin
            xCnt_r <= '0;
            yCnt_r <= '0;
        end else if (iEn) begin
            if (xCnt_r == X_LAST) begin
                xCnt_r <= '0;
                yCnt_r <= yCnt_r + 10'd1;
            end else begin
                xCnt_r <= xCnt_r + 10'd1;
                yCnt_r <= yCnt_r;
            end
        end else begin
            xCnt_r <= xCnt_r;
            yCnt_r <= yCnt_r;
        end
    end

    assign oX     = xCnt_r;
    assign oY     = yCnt_r;
    assign oXLast = (xCnt_r == X_LAST);
    assign oYLast = (yCnt_r == Y_LAST);

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Sequencer in front of the 3x3 Sobel stage: tags pixels with X/Y, latches the
// filter at frame start, and flushes the line buffer with zero pixels after each frame.
module sobel_stream_ctrl
    import sobel_pkg::*;
#(
    parameter int H_ACT     = H_ACT_DEF,
    parameter int V_ACT     = V_ACT_DEF,
    parameter int FLUSH_LEN = H_ACT + 1,
    parameter int DW        = DW_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iDVAL,
    input  logic [DW-1:0] iGRAY,
    input  logic [1:0]    iMODE,
    input  logic          iSTART,
    output logic          oREADY,
    output logic          oDVAL,
    output logic [DW-1:0] oGRAY,
    output logic [9:0]    oX,
    output logic [9:0]    oY,
    output logic          oFILTER,
    output logic          oFRAME_START,
    output logic          oFRAME_DONE,
    output logic [15:0]   oFRAME_CNT,
    output logic          oOVERRUN
);

    localparam logic [10:0] FLUSH_LAST = 11'(FLUSH_LEN - 1);

    ctrl_st_t      state_r;
    logic          ready_r;
    logic          dval_r;
    logic [DW-1:0] gray_r;
    coord_t        x_r;
    coord_t        y_r;
    logic          filter_r;
    logic          toggle_r;
    logic          frameStart_r;
    logic          frameDone_r;
    logic [15:0]   frameCnt_r;
    logic          overrun_r;
    logic [10:0]   flushCnt_r;

    coord_t cntX_s;
    coord_t cntY_s;
    logic   xLast_s;
    logic   yLast_s;
    logic   accept_s;
    logic   lastPix_s;
    logic   flushLast_s;
    logic   cntEn_s;
    logic   cntClr_s;

    // ready_r always mirrors "state is ARM or STREAM", so accept is a flop-only decode.
    assign accept_s    = iDVAL & ready_r;
    assign lastPix_s   = xLast_s & yLast_s;
    assign flushLast_s = (flushCnt_r == FLUSH_LAST);
    assign cntEn_s     = accept_s | (state_r == FLUSH);
    assign cntClr_s    = (state_r == FLUSH) & flushLast_s;

    sobel_xy_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) uXyCnt (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iEn    (cntEn_s),
        .iClr   (cntClr_s),
        .oX     (cntX_s),
        .oY     (cntY_s),
        .oXLast (xLast_s),
        .oYLast (yLast_s)
    );

    // Frame sequencer with registered pixel outputs, filter latch and frame counter.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_r      <= IDLE;
            ready_r      <= 1'b0;
            dval_r       <= 1'b0;
            gray_r       <= {DW{1'b0}};
            x_r          <= '0;
            y_r          <= '0;
            filter_r     <= 1'b0;
            toggle_r     <= 1'b0;
            frameStart_r <= 1'b0;
            frameDone_r  <= 1'b0;
            frameCnt_r   <= 16'd0;
            flushCnt_r   <= 11'd0;
        end else begin
            dval_r       <= 1'b0;
            frameStart_r <= 1'b0;
            frameDone_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (iSTART) begin
                        state_r <= ARM;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        ready_r <= 1'b0;
                    end
                end
                ARM: begin
                    if (accept_s) begin
                        dval_r       <= 1'b1;
                        gray_r       <= iGRAY;
                        x_r          <= cntX_s;
                        y_r          <= cntY_s;
                        frameStart_r <= 1'b1;
                        filter_r     <= filterFor(iMODE, toggle_r);
                        toggle_r     <= iMODE[1] ? ~toggle_r : toggle_r;
                        state_r      <= lastPix_s ? FLUSH : STREAM;
                        ready_r      <= ~lastPix_s;
                    end else begin
                        state_r <= ARM;
                        ready_r <= 1'b1;
                    end
                end
                STREAM: begin
                    if (accept_s) begin
                        dval_r  <= 1'b1;
                        gray_r  <= iGRAY;
                        x_r     <= cntX_s;
                        y_r     <= cntY_s;
                        state_r <= lastPix_s ? FLUSH : STREAM;
                        ready_r <= ~lastPix_s;
                    end else begin
                        state_r <= STREAM;
                        ready_r <= 1'b1;
                    end
                end
                FLUSH: begin
                    dval_r <= 1'b1;
                    gray_r <= {DW{1'b0}};
                    x_r    <= cntX_s;
                    y_r    <= cntY_s;
                    if (flushLast_s) begin
                        frameDone_r <= 1'b1;
                        frameCnt_r  <= frameCnt_r + 16'd1;
                        flushCnt_r  <= 11'd0;
                        state_r     <= ARM;
                        ready_r     <= 1'b1;
                    end else begin
                        flushCnt_r <= flushCnt_r + 11'd1;
                        state_r    <= FLUSH;
                        ready_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: a pixel offered while stalled wins over a same-cycle iSTART clear.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            overrun_r <= 1'b0;
        end else if (iDVAL & ~ready_r) begin
            overrun_r <= 1'b1;
        end else if (iSTART) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign oREADY       = ready_r;
    assign oDVAL        = dval_r;
    assign oGRAY        = gray_r;
    assign oX           = x_r;
    assign oY           = y_r;
    assign oFILTER      = filter_r;
    assign oFRAME_START = frameStart_r;
    assign oFRAME_DONE  = frameDone_r;
    assign oFRAME_CNT   = frameCnt_r;
    assign oOVERRUN     = overrun_r;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed bench for sobel_stream_ctrl on a 4x3 frame with a 5-pixel flush.
module tb_sobel_stream_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int FL = H + 1;
    localparam int NP = H * V;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iDVAL;
    logic [11:0] iGRAY;
    logic [1:0]  iMODE;
    logic        iSTART;
    logic        oREADY;
    logic        oDVAL;
    logic [11:0] oGRAY;
    logic [9:0]  oX;
    logic [9:0]  oY;
    logic        oFILTER;
    logic        oFRAME_START;
    logic        oFRAME_DONE;
    logic [15:0] oFRAME_CNT;
    logic        oOVERRUN;

    int testCnt = 0;
    int failCnt = 0;

    sobel_stream_ctrl #(
        .H_ACT     (H),
        .V_ACT     (V),
        .FLUSH_LEN (FL),
        .DW        (12)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iDVAL        (iDVAL),
        .iGRAY        (iGRAY),
        .iMODE        (iMODE),
        .iSTART       (iSTART),
        .oREADY       (oREADY),
        .oDVAL        (oDVAL),
        .oGRAY        (oGRAY),
        .oX           (oX),
        .oY           (oY),
        .oFILTER      (oFILTER),
        .oFRAME_START (oFRAME_START),
        .oFRAME_DONE  (oFRAME_DONE),
        .oFRAME_CNT   (oFRAME_CNT),
        .oOVERRUN     (oOVERRUN)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [11:0] grayOf(input int p, input int seed);
        return 12'((p * 37 + seed * 5 + 1) & 32'hFFF);
    endfunction

    // One frame from ARM: gapMask bit k forces iDVAL low on step k.
    task automatic runFrame(input logic [1:0] mode, input logic [15:0] gapMask, input int seed,
                            input logic expFilt, input logic [15:0] expCnt,
                            input bit flipMid, input bit holdFlush);
        int p = 0;
        int k = 0;
        iMODE = mode;
        while (p < NP && k < 64) begin
            if (gapMask[k % 16]) begin
                iDVAL = 1'b0;
                tick();
                checkVal("gapDval", oDVAL, 0);
                checkVal("gapStart", oFRAME_START, 0);
                checkVal("gapReady", oREADY, 1);
            end else begin
                iDVAL = 1'b1;
                iGRAY = grayOf(p, seed);
                tick();
                checkVal("pixDval", oDVAL, 1);
                checkVal("pixGray", oGRAY, grayOf(p, seed));
                checkVal("pixX", oX, p % H);
                checkVal("pixY", oY, p / H);
                checkVal("pixStart", oFRAME_START, (p == 0) ? 1 : 0);
                checkVal("pixFilter", oFILTER, expFilt);
                checkVal("pixReady", oREADY, (p == NP - 1) ? 0 : 1);
                checkVal("pixFrameCnt", oFRAME_CNT, 16'(expCnt - 16'd1));
                p++;
                if (flipMid && p == 1) iMODE = mode ^ 2'b11;
            end
            k++;
        end
        checkVal("pixFedCount", p, NP);
        iDVAL = holdFlush;
        iGRAY = 12'hFFF;
        for (int f = 0; f < FL; f++) begin
            tick();
            checkVal("flushDval", oDVAL, 1);
            checkVal("flushGray", oGRAY, 0);
            checkVal("flushX", oX, f % H);
            checkVal("flushY", oY, V + f / H);
            checkVal("flushDone", oFRAME_DONE, (f == FL - 1) ? 1 : 0);
            checkVal("flushFrameCnt", oFRAME_CNT, (f == FL - 1) ? expCnt : 16'(expCnt - 16'd1));
            checkVal("flushReady", oREADY, (f == FL - 1) ? 1 : 0);
            checkVal("flushFilter", oFILTER, expFilt);
        end
        iDVAL = 1'b0;
        iMODE = mode;
        checkVal("overrunAfterFrame", oOVERRUN, holdFlush);
    endtask

    initial begin
        iRST   = 1'b0;
        iDVAL  = 1'b0;
        iGRAY  = 12'd0;
        iMODE  = 2'b00;
        iSTART = 1'b0;
        tick();
        tick();
        checkVal("rstReady", oREADY, 0);
        checkVal("rstDval", oDVAL, 0);
        checkVal("rstFrameCnt", oFRAME_CNT, 0);
        checkVal("rstOverrun", oOVERRUN, 0);
        iRST = 1'b1;
        tick();
        checkVal("idleReady", oREADY, 0);
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        checkVal("armReady", oREADY, 1);

        runFrame(2'b00, 16'h0000, 1, 1'b0, 16'd1, 1'b0, 1'b0);
        runFrame(2'b10, 16'hA5A5, 2, 1'b0, 16'd2, 1'b1, 1'b0);
        runFrame(2'b10, 16'h3C3C, 3, 1'b1, 16'd3, 1'b1, 1'b0);
        runFrame(2'b11, 16'h0000, 4, 1'b0, 16'd4, 1'b0, 1'b0);
        runFrame(2'b01, 16'h0101, 5, 1'b1, 16'd5, 1'b0, 1'b1);

        // iSTART while armed only clears the sticky overrun
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        checkVal("startClrOverrun", oOVERRUN, 0);
        checkVal("startArmReady", oREADY, 1);

        // Partial frame up to pixel (2,1), then asynchronous reset
        iMODE = 2'b00;
        for (int p = 0; p < 7; p++) begin
            iDVAL = 1'b1;
            iGRAY = grayOf(p, 7);
            tick();
        end
        iDVAL = 1'b0;
        checkVal("partX", oX, 2);
        checkVal("partY", oY, 1);
        iRST = 1'b0;
        #2;
        checkVal("midRstReady", oREADY, 0);
        checkVal("midRstDval", oDVAL, 0);
        checkVal("midRstGray", oGRAY, 0);
        checkVal("midRstX", oX, 0);
        checkVal("midRstY", oY, 0);
        checkVal("midRstFilter", oFILTER, 0);
        checkVal("midRstFrameCnt", oFRAME_CNT, 0);
        #2;
        iRST = 1'b1;
        tick();
        checkVal("postRstIdle", oREADY, 0);
        iDVAL = 1'b1;
        tick();
        iDVAL = 1'b0;
        checkVal("idleDvalOverrun", oOVERRUN, 1);
        checkVal("idleDvalDropped", oDVAL, 0);
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        checkVal("idleStartClr", oOVERRUN, 0);
        checkVal("restartReady", oREADY, 1);
        runFrame(2'b10, 16'h0000, 6, 1'b0, 16'd1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
